// File: rtl/aes_eim_slave_if.sv
// EIM bus bundle between the i.MX external interface (master) and an EIM slave.
//   eim_cs_n   : chip select, active-low
//   eim_lba_n  : address-valid strobe, active-low
//   eim_rw     : 1 = read, 0 = write (meaningful in the address phase)
//   eim_a      : upper address bits [18:16]
//   eim_da_in  : multiplexed address/data from the pad
//   eim_da_out : read data to the pad
//   eim_da_oe  : pad output enable
interface aes_eim_slave_if;
    logic        eim_cs_n;
    logic        eim_lba_n;
    logic        eim_rw;
    logic [2:0]  eim_a;
    logic [15:0] eim_da_in;
    logic [15:0] eim_da_out;
    logic        eim_da_oe;

    modport master (
        output eim_cs_n, eim_lba_n, eim_rw, eim_a, eim_da_in,
        input  eim_da_out, eim_da_oe
    );

    modport slave (
        input  eim_cs_n, eim_lba_n, eim_rw, eim_a, eim_da_in,
        output eim_da_out, eim_da_oe
    );
endinterface

// File: rtl/aes_eim_slave.sv
// EIM register slave fronting an AES cipher core.
// Word map (5-bit word address taken from eim_da_in[4:0] in the address phase):
//   0x00-0x07 key (RW), 0x08-0x0F text_in (RW), 0x10-0x17 result (RO),
//   0x18 CTRL (write bit0 = start; read {14'b0, busy, result_valid}), 0x19 ID (RO),
//   all other words read 0 and ignore writes. Bursts wrap 0x1F -> 0x00.
// Ports:
//   clk, rst  : EIM_BCLK clock, asynchronous active-high reset
//   eim       : EIM bus (slave modport)
//   key       : cipher key, word 0 = key[15:0]
//   text_in   : plaintext, word 8 = text_in[15:0]
//   ld        : one-cycle start pulse to the core
//   done      : core completion pulse, text_out valid in that cycle
//   text_out  : core result
// Build option: define AES_EIM_READBACK_EN to make key/text_in readable; otherwise
// those words read back as 0.
module aes_eim_slave #(
    parameter logic [15:0] ID_VALUE      = 16'hAE51,
    parameter int unsigned START_ON_TEXT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_eim_slave_if.slave       eim,
    output logic [127:0]         key,
    output logic [127:0]         text_in,
    output logic                 ld,
    input  logic                 done,
    input  logic [127:0]         text_out
);
    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e       state_q, state_d;
    logic [4:0]   addr_q, addr_d;
    logic [15:0]  da_out_q, da_out_d;
    logic [127:0] key_q, key_d;
    logic [127:0] text_q, text_d;
    logic [127:0] result_q, result_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic         ld_q, ld_d;

    logic [4:0]   addr_in;
    logic [4:0]   rd_addr;
    logic [15:0]  rd_word;
    logic         start_req;
    logic         start_ok;
    logic         unused_addr_hi;

    // Only the low five address bits select a word; eim_a is above them.
    assign addr_in        = eim.eim_da_in[4:0];
    assign unused_addr_hi = ^eim.eim_a;

    // An address phase reads the freshly presented word; data cycles read the burst pointer.
    assign rd_addr = eim.eim_lba_n ? addr_q : addr_in;

    always_comb begin
        rd_word = 16'h0000;
        if (!rd_addr[4]) begin
`ifdef AES_EIM_READBACK_EN
            if (!rd_addr[3]) begin
                rd_word = key_q[{rd_addr[2:0], 4'b0000} +: 16];
            end else begin
                rd_word = text_q[{rd_addr[2:0], 4'b0000} +: 16];
            end
`else
            rd_word = 16'h0000;
`endif
        end else if (!rd_addr[3]) begin
            rd_word = result_q[{rd_addr[2:0], 4'b0000} +: 16];
        end else if (rd_addr == 5'h18) begin
            rd_word = {14'b0, busy_q, valid_q};
        end else if (rd_addr == 5'h19) begin
            rd_word = ID_VALUE;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        da_out_d  = da_out_q;
        key_d     = key_q;
        text_d    = text_q;
        result_d  = result_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        start_req = 1'b0;

        if (eim.eim_cs_n) begin
            state_d = StIdle;
        end else if (!eim.eim_lba_n) begin
            // Address phase restarts a transfer from any state.
            state_d = eim.eim_rw ? StRead : StWrite;
            addr_d  = addr_in;
            if (eim.eim_rw) begin
                da_out_d = rd_word;
                addr_d   = addr_in + 5'd1;
            end
        end else begin
            case (state_q)
                StWrite: begin
                    addr_d = addr_q + 5'd1;
                    if (!addr_q[4]) begin
                        // Operand words are frozen while the core is running.
                        if (!busy_q) begin
                            if (!addr_q[3]) begin
                                key_d[{addr_q[2:0], 4'b0000} +: 16] = eim.eim_da_in;
                            end else begin
                                text_d[{addr_q[2:0], 4'b0000} +: 16] = eim.eim_da_in;
                            end
                        end
                        if (START_ON_TEXT != 0 && addr_q == 5'h0F) begin
                            start_req = 1'b1;
                        end
                    end else if (addr_q == 5'h18) begin
                        start_req = eim.eim_da_in[0];
                    end
                end
                StRead: begin
                    da_out_d = rd_word;
                    addr_d   = addr_q + 5'd1;
                end
                default: ;
            endcase
        end

        // A completing core frees itself, so a start in the done cycle is accepted.
        start_ok = start_req && (!busy_q || done);
        if (done) begin
            result_d = text_out;
            busy_d   = 1'b0;
            valid_d  = 1'b1;
        end
        if (start_ok) begin
            busy_d  = 1'b1;
            valid_d = 1'b0;
        end
        ld_d = start_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= 5'd0;
            da_out_q <= 16'h0000;
            key_q    <= 128'h0;
            text_q   <= 128'h0;
            result_q <= 128'h0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            ld_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            da_out_q <= da_out_d;
            key_q    <= key_d;
            text_q   <= text_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            ld_q     <= ld_d;
        end
    end

    assign key            = key_q;
    assign text_in        = text_q;
    assign ld             = ld_q;
    assign eim.eim_da_out = da_out_q;
    assign eim.eim_da_oe  = (state_q == StRead) && !eim.eim_cs_n;
endmodule

// File: tb/tb_aes_eim_slave.sv
// Directed bench for aes_eim_slave: a word-level register model predicts key, text_in,
// ld, eim_da_oe and read data; one negedge process compares every cycle, and a set of
// literal expectations pins the model to hand-computed values.
module tb_aes_eim_slave;
    localparam int unsigned StartOnText = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key;
    logic [127:0] text_in;
    logic         ld;
    logic         done = 1'b0;
    logic [127:0] text_out = 128'h0;

    aes_eim_slave_if bus ();

    aes_eim_slave #(
        .ID_VALUE      (16'hAE51),
        .START_ON_TEXT (StartOnText)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .eim      (bus),
        .key      (key),
        .text_in  (text_in),
        .ld       (ld),
        .done     (done),
        .text_out (text_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic [127:0] m_key = '0, m_text = '0, m_res = '0;
    bit           m_busy = 0, m_rv = 0;
    int           ncyc = 0;
    int           exp_ld_at = -1;
    bit           exp_oe = 0;
    bit           exp_dv = 0;
    logic [15:0]  exp_dout = '0;
    bit           chk_en = 0;
    logic [15:0]  rd_got [0:7];

    localparam logic [127:0] Tout1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Tout2 = 128'h0123456789abcdeffedcba9876543210;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] mdl_word(input logic [4:0] a);
        logic [15:0] w;
        w = 16'h0000;
        if (a < 5'd16) begin
`ifdef AES_EIM_READBACK_EN
            w = (a < 5'd8) ? m_key[int'(a[2:0])*16 +: 16] : m_text[int'(a[2:0])*16 +: 16];
`endif
        end else if (a < 5'd24) begin
            w = m_res[int'(a[2:0])*16 +: 16];
        end else if (a == 5'd24) begin
            w = {14'b0, m_busy, m_rv};
        end else if (a == 5'd25) begin
            w = 16'hAE51;
        end
        return w;
    endfunction

    // Effect of one accepted data-cycle write at word wa, with optional done in that cycle.
    task automatic mdl_write(input logic [4:0] wa, input logic [15:0] d, input bit dn,
                             input logic [127:0] tout);
        bit start, acc;
        start = 0;
        if (wa < 5'd16) begin
            if (!m_busy) begin
                if (wa < 5'd8) m_key[int'(wa[2:0])*16 +: 16] = d;
                else           m_text[int'(wa[2:0])*16 +: 16] = d;
            end
            if (StartOnText != 0 && wa == 5'd15) start = 1;
        end else if (wa == 5'd24) begin
            start = d[0];
        end
        acc = start && (!m_busy || dn);
        if (dn) begin
            m_res = tout; m_busy = 0; m_rv = 1;
        end
        if (acc) begin
            m_busy = 1; m_rv = 0; exp_ld_at = ncyc + 1;
        end
    endtask

    task automatic mdl_reset();
        m_key = '0; m_text = '0; m_res = '0; m_busy = 0; m_rv = 0;
        exp_ld_at = -1; exp_oe = 0; exp_dv = 0;
    endtask

    // Upper address bits and eim_a carry junk to show they are ignored.
    task automatic addr_phase(input logic [4:0] a, input logic rw);
        bus.eim_cs_n = 1'b0; bus.eim_lba_n = 1'b0; bus.eim_rw = rw;
        bus.eim_a = 3'b101; bus.eim_da_in = {11'h5A3, a}; exp_oe = 0;
    endtask

    task automatic bus_idle();
        bus.eim_cs_n = 1'b1; bus.eim_lba_n = 1'b1; exp_oe = 0;
    endtask

    // All bus tasks start and end #1 after a rising edge.
    task automatic wr_burst(input logic [4:0] a, input int n, input logic [15:0] base,
                            input logic [15:0] step, input bit dn, input logic [127:0] tout);
        logic [15:0] d;
        addr_phase(a, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            d = base + step * 16'(i);
            bus.eim_lba_n = 1'b1; bus.eim_rw = 1'b1; bus.eim_da_in = d;
            if (dn && i == 0) begin done = 1'b1; text_out = tout; end
            @(posedge clk);
            mdl_write(a + 5'(i), d, dn && i == 0, tout);
            #1; done = 1'b0; text_out = ~tout;
        end
        bus_idle();
        @(posedge clk); #1;
    endtask

    task automatic rd_burst(input logic [4:0] a, input int n);
        addr_phase(a, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            exp_dout = mdl_word(a + 5'(i)); exp_dv = 1;
            #1; rd_got[i] = bus.eim_da_out;
            if (i < n - 1) begin
                bus.eim_lba_n = 1'b1; bus.eim_rw = 1'b0; bus.eim_da_in = 16'hFFFF; exp_oe = 1;
            end else begin
                bus_idle();
            end
        end
        @(posedge clk); exp_dv = 0; #1;
    endtask

    task automatic pulse_done(input logic [127:0] tout);
        done = 1'b1; text_out = tout;
        @(posedge clk);
        m_res = tout; m_busy = 0; m_rv = 1;
        #1; done = 1'b0; text_out = ~tout;
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (chk_en) begin
            check("ld", 128'(ld), 128'(ncyc == exp_ld_at));
            check("da_oe", 128'(bus.eim_da_oe), 128'(exp_oe));
            check("key", key, m_key);
            check("text_in", text_in, m_text);
            if (exp_dv) check("da_out", 128'(bus.eim_da_out), 128'(exp_dout));
        end
    end

    initial begin
        bus.eim_cs_n = 1'b1; bus.eim_lba_n = 1'b1; bus.eim_rw = 1'b0;
        bus.eim_a = 3'b000; bus.eim_da_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_key", key, 128'h0);
        check("rst_text", text_in, 128'h0);
        check("rst_ld", 128'(ld), 128'h0);
        check("rst_oe", 128'(bus.eim_da_oe), 128'h0);
        check("rst_dout", 128'(bus.eim_da_out), 128'h0);
        rst = 1'b0;
        chk_en = 1;
        @(posedge clk); #1;

        wr_burst(5'h00, 8, 16'h0001, 16'h0001, 0, '0);
        check("key_burst", key, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        wr_burst(5'h08, 8, 16'h1000, 16'h0111, 0, '0);

        rd_burst(5'h18, 1);
        check("ctrl_idle", 128'(rd_got[0]), 128'h0000);
        wr_burst(5'h18, 1, 16'h0001, 16'h0000, 0, '0);
        rd_burst(5'h18, 1);
        check("ctrl_busy", 128'(rd_got[0]), 128'h0002);

        pulse_done(Tout1);
        rd_burst(5'h18, 1);
        check("ctrl_valid", 128'(rd_got[0]), 128'h0001);
        rd_burst(5'h10, 8);
        check("res_w0", 128'(rd_got[0]), 128'h0b32);
        check("res_w1", 128'(rd_got[1]), 128'h196a);
        check("res_w7", 128'(rd_got[7]), 128'h3925);

        rd_burst(5'h19, 1);
        check("id", 128'(rd_got[0]), 128'hAE51);

        rd_burst(5'h1E, 3);
        check("wrap_1e", 128'(rd_got[0]), 128'h0000);
        check("wrap_1f", 128'(rd_got[1]), 128'h0000);
`ifdef AES_EIM_READBACK_EN
        check("wrap_00", 128'(rd_got[2]), 128'h0001);
`else
        check("wrap_00", 128'(rd_got[2]), 128'h0000);
`endif

        // Start, locked key write, start while busy, start coincident with done.
        wr_burst(5'h18, 1, 16'h0001, 16'h0000, 0, '0);
        wr_burst(5'h00, 1, 16'hFFFF, 16'h0000, 0, '0);
        wr_burst(5'h18, 1, 16'h0001, 16'h0000, 0, '0);
        wr_burst(5'h18, 1, 16'h0001, 16'h0000, 1, Tout2);
        rd_burst(5'h18, 1);
        check("ctrl_restart", 128'(rd_got[0]), 128'h0002);
        rd_burst(5'h10, 1);
        check("res2_w0", 128'(rd_got[0]), 128'h3210);
        pulse_done(Tout2);

        // Write burst wrapping past 0x1F lands on key word 0.
        wr_burst(5'h1F, 2, 16'h5A5A, 16'h0000, 0, '0);
        check("key_wrap", 128'(key[15:0]), 128'h5A5A);

        // Reset in the data cycle of word 0x03, then orphaned data cycles.
        addr_phase(5'h00, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus.eim_lba_n = 1'b1; bus.eim_da_in = 16'h0100 + 16'(i);
            @(posedge clk);
            mdl_write(5'(i), 16'h0100 + 16'(i), 0, '0);
            #1;
        end
        bus.eim_da_in = 16'h0103;
        rst = 1'b1;
        mdl_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.eim_da_in = 16'hDEAD;
            @(posedge clk); #1;
        end
        bus_idle();
        @(posedge clk); #1;
        check("rst_mid_key", key, 128'h0);
        rd_burst(5'h18, 1);
        check("rst_mid_ctrl", 128'(rd_got[0]), 128'h0000);
        rd_burst(5'h00, 1);
        check("rst_mid_rd0", 128'(rd_got[0]), 128'h0000);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_eim_slave.md
AES_EIM_SLAVE -- requirements
Module: aes_eim_slave

Interface
REQ-001 SHALL have parameter ID_VALUE, default 16'hAE51, constant returned by the ID register.
REQ-002 SHALL have parameter START_ON_TEXT, default 0; when 1, a write to word 0x0F also issues a start.
REQ-003 SHALL have port clk  in  1  EIM_BCLK-domain clock; all EIM inputs sampled on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; one clock, asynchronous, active-high.
REQ-005 SHALL have port eim_cs_n  in  1  chip select, active-low.
REQ-006 SHALL have port eim_lba_n  in  1  address-valid strobe, active-low.
REQ-007 SHALL have port eim_rw  in  1  1 = read, 0 = write; sampled in the address phase.
REQ-008 SHALL have port eim_a  in  3  upper address bits [18:16].
REQ-009 SHALL have port eim_da_in  in  16  multiplexed address/data from the pad.
REQ-010 SHALL have port eim_da_out  out  16  read data to the pad.
REQ-011 SHALL have port eim_da_oe  out  1  pad output enable.
REQ-012 SHALL have port key  out  128  cipher key; word 0 = key[15:0].
REQ-013 SHALL have port text_in  out  128  plaintext; word 8 = text_in[15:0].
REQ-014 SHALL have port ld  out  1  one-cycle start pulse to the cipher core.
REQ-015 SHALL have port done  in  1  cipher core completion pulse.
REQ-016 SHALL have port text_out  in  128  cipher core result; valid in the cycle done=1.

Function
REQ-017 Word address SHALL be {eim_a, eim_da_in}[4:0]; upper bits are ignored.
REQ-018 Map SHALL be: 0x00-0x07 key (RW); 0x08-0x0F text_in (RW); 0x10-0x17 result (RO).
REQ-019 Map SHALL continue: 0x18 CTRL (write bit0=1 -> start; read {14'b0, busy, result_valid}); 0x19 ID (RO); others read 0, writes ignored.
REQ-020 FSM SHALL have states IDLE, WRITE and READ.
REQ-021 In IDLE, a cycle with cs_n=0 and lba_n=0 SHALL latch the address and go to WRITE (rw=0) or READ (rw=1).
REQ-022 Any cycle with cs_n=1 SHALL return the FSM to IDLE; lba_n=0 with cs_n=0 in any state SHALL restart the address phase.
REQ-023 WRITE: each cycle with cs_n=0 and lba_n=1 SHALL store eim_da_in to the current word, then increment the address.
REQ-024 READ: eim_da_out SHALL be registered; the word at address N appears one cycle after the address phase, then advances one word per cycle.
REQ-025 eim_da_oe SHALL be 1 only in READ with cs_n=0.
REQ-026 Burst increments SHALL wrap 0x1F -> 0x00 (5-bit wrap).
REQ-027 A start SHALL assert ld for exactly one cycle, set busy=1 and clear result_valid.
REQ-028 A start while busy=1 SHALL be ignored.
REQ-029 done=1 SHALL capture text_out into the result register, clear busy and set result_valid.
REQ-030 done and an accepted start in the same cycle SHALL capture the result and leave busy=1, result_valid=0.
REQ-031 Writes to key or text_in while busy=1 SHALL be discarded.

Reset
REQ-032 rst SHALL force: FSM IDLE; eim_da_out=0; eim_da_oe=0; ld=0; busy=0; result_valid=0; key=128'h0; text_in=128'h0; result=128'h0.
REQ-033 Reset during a burst SHALL abort it; no partial word is written after rst deasserts until a new address phase.

Configuration
REQ-034 Macro AES_EIM_READBACK_EN SHALL gate key/text_in readback.
REQ-035 With AES_EIM_READBACK_EN defined, reads of 0x00-0x0F SHALL return the stored words.
REQ-036 Without AES_EIM_READBACK_EN, reads of 0x00-0x0F SHALL return 16'h0000; writes are unaffected.

Verification
REQ-037 Write burst at 0x00 of 8 words 0x0001..0x0008 -> key=128'h0008_0007_..._0001, ld stays 0.
REQ-038 Write 0x0001 to 0x18 -> ld high for one cycle, CTRL reads 0x0002; then done with text_out=128'h3925841d02dc09fbdc118597196a0b32 -> CTRL reads 0x0001 and a burst read at 0x10 returns 0x0b32, 0x196a, ...
REQ-039 Read burst at 0x1E of 3 words -> 0x0000, 0x0000 (wrap to key word 0 returns key[15:0] with the macro, 0x0000 without).
REQ-040 Single read at 0x19 -> 16'hAE51 one cycle after the address phase, eim_da_oe=1 only while cs_n=0.
REQ-041 Start while busy, then start coincident with done -> second ld suppressed, third accepted, result captured, busy=1.
REQ-042 Assert rst mid write burst at word 0x03 -> key reads 0, FSM IDLE, subsequent data cycles with lba_n=1 write nothing.
